serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parallel-to-serial frame transmitter. It accepts one DATA_W-bit word over a valid/ready handshake and shifts it out on a single line as a framed serial stream: start bit, data LSB first, optional parity bit, stop bit. It is the transmit end of the team's serial link and is built entirely from resettable flip-flop state. Like the team's flip-flops, all state updates on the falling edge of clk.

## Interface
Parameters:
- DATA_W, 8: data bits per frame; must be at least 1.
- CLKS_PER_BIT, 4: clk cycles each serial bit is held; must be at least 1.

Ports:
- clk  input  1  single clock; all registers update on the falling edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  word to transmit; sampled only at the handshake edge.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  transmitter can accept a word (high only in IDLE).
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse after the stop bit completes.

## Operation
- FSM states and transitions:
  - IDLE -> START on handshake (in_valid && in_ready at a falling edge).
  - START -> DATA.
  - DATA -> PARITY, or DATA -> STOP when parity is compiled out.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Handshake: the word is latched into a shift register and the FSM enters START at the same edge. in_valid is ignored outside IDLE. data_in changes after the handshake have no effect.
- tx value by state:
  - IDLE: 1.
  - START: 0.
  - DATA: current shift-register LSB; shifts right once per bit period, DATA_W bits, LSB first.
  - PARITY: even parity, the XOR of the latched word.
  - STOP: 1.
- tx is driven from a register, so there are no combinational glitches.
- Counters:
  - The cycle counter counts 0..CLKS_PER_BIT-1 and advances the state or bit at the terminal count. Width is $clog2(CLKS_PER_BIT), minimum 1.
  - The bit counter counts 0..DATA_W-1 in DATA. Width is $clog2(DATA_W), minimum 1.
  - Both counters clear on every state change.
- done: goes high at the STOP -> IDLE edge and clears at the next edge.
- Reset values: tx=1, busy=0, in_ready=1, done=0, FSM=IDLE, counters=0, shift register=0.
- Reset mid-frame: all outputs return to their reset values immediately, without waiting for a clock edge. The word is discarded and no done pulse is produced.

## Timing
- Handshake-to-start latency: 0. tx falls at the handshake edge.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT with parity.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; no state may be skipped.
- Back-to-back frames: in_ready and done are both high in the first IDLE cycle. A word presented then is accepted at the end of that cycle, so there is exactly 1 idle-high cycle between a stop bit and the next start bit.
- rst deasserting at a falling edge: the first handshake can occur at the following falling edge.

## Configuration
- SERIAL_FRAME_TX_PARITY_EN defined: the PARITY state is present and one even-parity bit is sent between the data and stop bits.
- SERIAL_FRAME_TX_PARITY_EN undefined: the PARITY state and the parity logic are absent; DATA goes directly to STOP.

## Test plan
All scenarios use DATA_W=8, CLKS_PER_BIT=4.
- Reset: assert rst with clk stopped -> tx=1, busy=0, in_ready=1, done=0 immediately.
- Send 8'hA5, no parity -> tx holds each of 0,1,0,1,0,0,1,0,1,1 for 4 clocks; done pulses once at clock 40; busy is high for 40 clocks.
- SERIAL_FRAME_TX_PARITY_EN, send 8'h07 -> data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop bit; frame lasts 44 clocks.
- in_valid held high with 8'h3C then 8'hC3 -> after the first frame's stop bit, tx is high for exactly 1 idle cycle, then the start bit of 8'hC3 follows.
- Toggle data_in and pulse in_valid during the frame for 8'hFF -> output is unchanged, in_ready=0 throughout, and only one done pulse occurs.
- Assert rst during data bit 3 -> tx=1 and busy=0 immediately, no done pulse; after release, 8'h01 transmits correctly.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Frame = start bit (0), DATA_W data bits LSB first, optional even parity
// bit, stop bit (1). Each bit is held CLKS_PER_BIT clk cycles.
// All state updates on the falling edge of clk; rst is asynchronous, active high.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN (adds the PARITY state
// and an even-parity bit between the data and stop bits).
//
// Handshake: a word is accepted at a falling edge where in_valid && in_ready.
// in_ready is high only in IDLE; in_valid and data_in are ignored otherwise.
// o_dbg_state mirrors the FSM state register for observation.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        o_dbg_state
);

    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [CYC_W-1:0]   r_cyc;
    logic [CYC_W-1:0]   w_cyc_next;
    logic [BIT_W-1:0]   r_bit;
    logic [BIT_W-1:0]   w_bit_next;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_next;
    logic               r_tx;
    logic               w_tx_next;
    logic               r_done;
    logic               w_done_next;
    logic               w_cyc_tick;
    logic               w_accept;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic               r_parity;
`endif

    assign w_cyc_tick = (r_cyc == CYC_LAST);
    assign w_accept   = (r_state == S_IDLE) && in_valid;

    // State, counters, shift register and registered tx/done.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cyc   <= w_cyc_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
        end
    end

`ifdef SERIAL_FRAME_TX_PARITY_EN
    // Parity of the whole word is captured at the handshake, since the
    // shift register is consumed while the data bits go out.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^data_in;
        end
    end
`endif

    // Next-state logic; tx_next is the line value for the state being entered,
    // so tx comes straight from a flop and changes exactly at the state edge.
    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_done_next  = 1'b0;
        w_cyc_next   = '0;

        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (w_accept) begin
                    w_state_next = S_START;
                    w_shift_next = data_in;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (w_cyc_tick) begin
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_cyc_tick) begin
                    if (r_bit == BIT_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        w_state_next = S_PARITY;
                        w_tx_next    = r_parity;
`else
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                        w_shift_next = r_shift >> 1;
                        w_tx_next    = w_shift_next[0];
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: begin
                if (w_cyc_tick) begin
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_cyc_tick) begin
                    w_state_next = S_IDLE;
                    w_tx_next    = 1'b1;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase

        // Both counters restart on any state change; the cycle counter
        // wraps at the end of each bit period and rests at 0 in IDLE.
        if (w_state_next != r_state) begin
            w_cyc_next = '0;
            w_bit_next = '0;
        end else if (r_state == S_IDLE || w_cyc_tick) begin
            w_cyc_next = '0;
        end else begin
            w_cyc_next = r_cyc + 1'b1;
        end
    end

    assign tx          = r_tx;
    assign done        = r_done;
    assign busy        = (r_state != S_IDLE);
    assign in_ready    = (r_state == S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx (DATA_W=8, CLKS_PER_BIT=4).
// DUT registers update on the falling edge; the bench drives and samples on
// the rising edge, midway between DUT updates.
module tb_serial_frame_tx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif

    logic              clk;
    logic              clk_en;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic              done;
    logic [2:0]        dbg_state;

    int n_checks;
    int n_fail;

    // Expected frames are hand-written: bit 0 is the start bit, the last
    // bit is the stop bit. exp_p carries the even-parity bit before stop.
    typedef struct {
        logic [7:0]  data;
        logic [9:0]  exp_np;
        logic [10:0] exp_p;
    } vec_t;

    vec_t vecs [8];

    serial_frame_tx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx          (tx),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    // Clock held still until the bench enables it.
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // Hard stop if something stalls the main sequence.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] exp_of(input int k);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        return vecs[k].exp_p;
`else
        return {1'b0, vecs[k].exp_np};
`endif
    endfunction

    // Sends one word starting from an idle rising edge and checks every
    // cycle of the frame plus the first IDLE cycle. disturb: random data_in
    // and in_valid during the frame. chain: leave in_valid high and stop at
    // the first IDLE cycle so the caller can present the next word there.
    task automatic send_frame(input logic [7:0] d, input logic [10:0] exp,
                              input bit disturb, input bit chain);
        check("pre_in_ready", 32'(in_ready), 32'd1);
        check("pre_tx", 32'(tx), 32'd1);
        data_in  = d;
        in_valid = 1'b1;
        @(posedge clk);
        if (!chain) in_valid = 1'b0;
        for (int i = 0; i < NBITS * CPB; i++) begin
            check("frame_tx", 32'(tx), 32'(exp[i / CPB]));
            check("frame_busy", 32'(busy), 32'd1);
            check("frame_in_ready", 32'(in_ready), 32'd0);
            check("frame_done", 32'(done), 32'd0);
            if (disturb) begin
                data_in  = 8'($urandom_range(0, 255));
                in_valid = (i < NBITS * CPB - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(posedge clk);
        end
        check("end_done", 32'(done), 32'd1);
        check("end_in_ready", 32'(in_ready), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_tx", 32'(tx), 32'd1);
        if (!chain) begin
            @(posedge clk);
            check("done_clear", 32'(done), 32'd0);
            check("idle_tx", 32'(tx), 32'd1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk_en   = 1'b0;
        rst      = 1'b0;
        data_in  = '0;
        in_valid = 1'b0;

        vecs[0] = '{8'hA5, 10'b1_10100101_0, 11'b1_0_10100101_0};
        vecs[1] = '{8'h07, 10'b1_00000111_0, 11'b1_1_00000111_0};
        vecs[2] = '{8'h3C, 10'b1_00111100_0, 11'b1_0_00111100_0};
        vecs[3] = '{8'hC3, 10'b1_11000011_0, 11'b1_0_11000011_0};
        vecs[4] = '{8'hFF, 10'b1_11111111_0, 11'b1_0_11111111_0};
        vecs[5] = '{8'h00, 10'b1_00000000_0, 11'b1_0_00000000_0};
        vecs[6] = '{8'h01, 10'b1_00000001_0, 11'b1_1_00000001_0};
        vecs[7] = '{8'h80, 10'b1_10000000_0, 11'b1_1_10000000_0};

        // Reset with the clock stopped: outputs must settle immediately.
        #2 rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);

        clk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);

        // Table of single frames.
        for (int k = 0; k < 8; k++) begin
            send_frame(vecs[k].data, exp_of(k), 1'b0, 1'b0);
        end

        // Traffic on data_in / in_valid during an 8'hFF frame is ignored.
        send_frame(8'hFF, exp_of(4), 1'b1, 1'b0);

        // Back-to-back: 8'h3C then 8'hC3 with in_valid held high; the
        // second start bit follows exactly one idle-high cycle.
        send_frame(8'h3C, exp_of(2), 1'b0, 1'b1);
        data_in = 8'hC3;
        send_frame(8'hC3, exp_of(3), 1'b0, 1'b0);

        // Reset during data bit 3 of 8'hA5 (bit 3 is 0, so tx=1 is visible).
        data_in  = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        in_valid = 1'b0;
        repeat (4 * CPB + 1) @(posedge clk);
        check("mid_pre_tx", 32'(tx), 32'd0);
        check("mid_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            check("mid_rst_hold_done", 32'(done), 32'd0);
            check("mid_rst_hold_tx", 32'(tx), 32'd1);
        end
        rst = 1'b0;
        @(posedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        send_frame(8'h01, exp_of(6), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
